// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: bundle between the control unit / register file and muldiv_unit.
//   Request side   : Start, Op, OperandA, OperandB, DestReg (and Signed when
//                    MULDIV_SIGNED_EN is defined).
//   Response side  : Busy, RegWrite, WriteReg, WriteData, DivByZero.
//   master modport : the issuing side (drives requests, sees responses).
//   slave modport  : muldiv_unit itself.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned REG_ADDR_W = 3
) ();
    logic                  Start;
    logic [1:0]            Op;
    logic [WIDTH-1:0]      OperandA;
    logic [WIDTH-1:0]      OperandB;
    logic [REG_ADDR_W-1:0] DestReg;
`ifdef MULDIV_SIGNED_EN
    logic                  Signed;
`endif
    logic                  Busy;
    logic                  RegWrite;
    logic [REG_ADDR_W-1:0] WriteReg;
    logic [WIDTH-1:0]      WriteData;
    logic                  DivByZero;

`ifdef MULDIV_SIGNED_EN
    modport master (
        output Start, Op, OperandA, OperandB, DestReg, Signed,
        input  Busy, RegWrite, WriteReg, WriteData, DivByZero
    );
    modport slave (
        input  Start, Op, OperandA, OperandB, DestReg, Signed,
        output Busy, RegWrite, WriteReg, WriteData, DivByZero
    );
`else
    modport master (
        output Start, Op, OperandA, OperandB, DestReg,
        input  Busy, RegWrite, WriteReg, WriteData, DivByZero
    );
    modport slave (
        input  Start, Op, OperandA, OperandB, DestReg,
        output Busy, RegWrite, WriteReg, WriteData, DivByZero
    );
`endif
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide execute unit, one bit per cycle.
//   Shift-add multiply (Op 00 low half, 01 high half) and restoring divide
//   (Op 10 quotient, 11 remainder). A request accepted in IDLE runs WIDTH
//   iterations, then spends one DONE cycle pulsing RegWrite toward the
//   register file write port.
// Ports:
//   clock    : system clock, all state on posedge
//   reset_n  : synchronous active-low reset
//   bus      : muldiv_unit_if.slave (Start/Op/OperandA/OperandB/DestReg in,
//              Busy/RegWrite/WriteReg/WriteData/DivByZero out)
// Optional feature: define MULDIV_SIGNED_EN to add the Signed request bit
//   (two's complement operands; iteration on magnitudes, sign fixed on the
//   way into DONE).
module muldiv_unit #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned REG_ADDR_W = 3
) (
    input logic          clock,
    input logic          reset_n,
    muldiv_unit_if.slave bus
);
    localparam int unsigned      CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    // hi: partial product / partial remainder; lo: multiplier / dividend->quotient
    logic [WIDTH:0]        hi_q, hi_d;
    logic [WIDTH-1:0]      lo_q, lo_d;
    logic [WIDTH-1:0]      b_q, b_d;
    logic [1:0]            op_q, op_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic                  neg_a_q, neg_a_d;
    logic                  neg_b_q, neg_b_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [REG_ADDR_W-1:0] wreg_q, wreg_d;

    logic                  sgn_in;
    logic                  a_neg_in;
    logic                  b_neg_in;
    logic [WIDTH:0]        mul_sum;
    logic [WIDTH:0]        div_shift;
    logic [WIDTH:0]        step_hi;
    logic [WIDTH-1:0]      step_lo;
    logic [2*WIDTH-1:0]    prod_mag;
    logic [2*WIDTH-1:0]    prod_fix;
    logic [WIDTH-1:0]      quo_fix;
    logic [WIDTH-1:0]      rem_fix;
    logic [WIDTH-1:0]      result;
    logic                  div_zero;

`ifdef MULDIV_SIGNED_EN
    assign sgn_in = bus.Signed;
`else
    assign sgn_in = 1'b0;
`endif

    assign a_neg_in = sgn_in & bus.OperandA[WIDTH-1];
    assign b_neg_in = sgn_in & bus.OperandB[WIDTH-1];
    assign div_zero = (b_q == '0);

    // One iteration of either algorithm, evaluated from the current state.
    always_comb begin
        mul_sum   = hi_q + {1'b0, ({WIDTH{lo_q[0]}} & b_q)};
        div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        step_hi   = hi_q;
        step_lo   = lo_q;
        if (op_q[1]) begin
            // Restoring divide: subtract only when it does not go negative.
            if (div_shift >= {1'b0, b_q}) begin
                step_hi = div_shift - {1'b0, b_q};
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift;
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Shift-add multiply: product ends up as {hi[WIDTH-1:0], lo}.
            step_hi = {1'b0, mul_sum[WIDTH:1]};
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Final result from the last iteration, with the sign fix-up applied so
    // DONE needs no extra cycle. Zero divisor forces an all-ones quotient; the
    // remainder naturally equals the dividend magnitude in that case.
    always_comb begin
        prod_mag = {step_hi[WIDTH-1:0], step_lo};
        prod_fix = (neg_a_q ^ neg_b_q) ? -prod_mag : prod_mag;
        if (div_zero) begin
            quo_fix = '1;
        end else begin
            quo_fix = (neg_a_q ^ neg_b_q) ? -step_lo : step_lo;
        end
        rem_fix = neg_a_q ? -step_hi[WIDTH-1:0] : step_hi[WIDTH-1:0];
        case (op_q)
            2'b00:   result = prod_fix[WIDTH-1:0];
            2'b01:   result = prod_fix[2*WIDTH-1:WIDTH];
            2'b10:   result = quo_fix;
            default: result = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        op_d    = op_q;
        dest_d  = dest_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        wdata_d = wdata_q;
        wreg_d  = wreg_q;
        case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = a_neg_in ? -bus.OperandA : bus.OperandA;
                    b_d     = b_neg_in ? -bus.OperandB : bus.OperandB;
                    op_d    = bus.Op;
                    dest_d  = bus.DestReg;
                    neg_a_d = a_neg_in;
                    neg_b_d = b_neg_in;
                end
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                hi_d  = step_hi;
                lo_d  = step_lo;
                if (cnt_q == LAST) begin
                    state_d = StDone;
                    // Write-back registers change only here so they hold
                    // their value outside DONE.
                    wdata_d = result;
                    wreg_d  = dest_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            op_q    <= '0;
            dest_q  <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            wdata_q <= '0;
            wreg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            op_q    <= op_d;
            dest_q  <= dest_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            wdata_q <= wdata_d;
            wreg_q  <= wreg_d;
        end
    end

    assign bus.Busy      = (state_q != StIdle);
    assign bus.RegWrite  = (state_q == StDone);
    assign bus.WriteReg  = wreg_q;
    assign bus.WriteData = wdata_q;
    assign bus.DivByZero = (state_q == StDone) && op_q[1] && div_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed, table-driven bench for muldiv_unit plus hand-written
// sequences for the handshake, mid-operation reset and reset-vs-Start cases.
module tb_muldiv_unit;
    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    muldiv_unit_if #(.WIDTH(16), .REG_ADDR_W(3)) bus ();

    muldiv_unit #(.WIDTH(16), .REG_ADDR_W(3)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          id;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  dest;
        logic        sg;
        logic [15:0] exp_data;
        logic        exp_dbz;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vector %0d): got 0x%0h expected 0x%0h", name, id, act, exp);
        end
    endtask

    task automatic drive(input logic start, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] d, input logic sg);
        bus.Start    = start;
        bus.Op       = op;
        bus.OperandA = a;
        bus.OperandB = b;
        bus.DestReg  = d;
`ifdef MULDIV_SIGNED_EN
        bus.Signed   = sg;
`else
        if (sg) bus.Start = start;
`endif
    endtask

    // Present a request at a negedge; returns #1 after the accepting edge E0.
    task automatic issue(input vec_t v);
        @(negedge clock);
        drive(1'b1, v.op, v.a, v.b, v.dest, v.sg);
        @(posedge clock);
        #1;
        drive(1'b0, 2'b00, 16'hA5A5, 16'h5A5A, 3'd0, 1'b0);
    endtask

    // Samples #1 after each edge E0.. until Busy drops (bounded).
    task automatic run_and_check(input vec_t v);
        int          first_rw;
        int          pulses;
        int          busy_cyc;
        int          stray;
        logic [15:0] data;
        logic [2:0]  wreg;
        logic        dbz;
        first_rw = -1;
        pulses   = 0;
        busy_cyc = 0;
        stray    = 0;
        data     = '0;
        wreg     = '0;
        dbz      = 1'b0;
        issue(v);
        for (int c = 0; c < 40; c++) begin
            if (bus.Busy) busy_cyc++;
            if (bus.RegWrite) begin
                pulses++;
                if (first_rw < 0) begin
                    first_rw = c;
                    data     = bus.WriteData;
                    wreg     = bus.WriteReg;
                    dbz      = bus.DivByZero;
                end
            end
            if (bus.DivByZero && !bus.RegWrite) stray++;
            if (!bus.Busy) break;
            @(posedge clock);
            #1;
        end
        check("latency", v.id, first_rw, 16);
        check("pulses", v.id, pulses, 1);
        check("busy_cycles", v.id, busy_cyc, 17);
        check("write_data", v.id, data, v.exp_data);
        check("write_reg", v.id, wreg, v.dest);
        check("div_by_zero", v.id, dbz, v.exp_dbz);
        check("stray_dbz", v.id, stray, 0);
        check("data_hold", v.id, bus.WriteData, v.exp_data);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        drive(1'b0, 2'b00, 16'h0000, 16'h0000, 3'd0, 1'b0);

        //            id  op     A        B        dst  sg    expect   dbz
        vecs.push_back('{ 0, 2'b00, 16'h0123, 16'h0456, 3'd1, 1'b0, 16'hEDC2, 1'b0});
        vecs.push_back('{ 1, 2'b01, 16'h0123, 16'h0456, 3'd2, 1'b0, 16'h0004, 1'b0});
        vecs.push_back('{ 2, 2'b10, 16'd1000, 16'd7,    3'd3, 1'b0, 16'h008E, 1'b0});
        vecs.push_back('{ 3, 2'b11, 16'd1000, 16'd7,    3'd4, 1'b0, 16'h0006, 1'b0});
        vecs.push_back('{ 4, 2'b10, 16'h1234, 16'h0000, 3'd5, 1'b0, 16'hFFFF, 1'b1});
        vecs.push_back('{ 5, 2'b11, 16'h1234, 16'h0000, 3'd6, 1'b0, 16'h1234, 1'b1});
        vecs.push_back('{ 6, 2'b00, 16'hFFFF, 16'hFFFF, 3'd7, 1'b0, 16'h0001, 1'b0});
        vecs.push_back('{ 7, 2'b01, 16'hFFFF, 16'hFFFF, 3'd0, 1'b0, 16'hFFFE, 1'b0});
        vecs.push_back('{ 8, 2'b10, 16'h8000, 16'hFFFF, 3'd1, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{ 9, 2'b11, 16'h8000, 16'hFFFF, 3'd2, 1'b0, 16'h8000, 1'b0});
        vecs.push_back('{10, 2'b10, 16'd5,    16'd9,    3'd3, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{11, 2'b11, 16'd5,    16'd9,    3'd4, 1'b0, 16'h0005, 1'b0});
        vecs.push_back('{12, 2'b10, 16'hFFFF, 16'h0001, 3'd5, 1'b0, 16'hFFFF, 1'b0});
`ifdef MULDIV_SIGNED_EN
        vecs.push_back('{20, 2'b10, 16'hFFF9, 16'h0002, 3'd1, 1'b1, 16'hFFFD, 1'b0});
        vecs.push_back('{21, 2'b11, 16'hFFF9, 16'h0002, 3'd2, 1'b1, 16'hFFFF, 1'b0});
        vecs.push_back('{22, 2'b01, 16'hFFFF, 16'hFFFF, 3'd3, 1'b1, 16'h0000, 1'b0});
        vecs.push_back('{23, 2'b00, 16'hFFFF, 16'hFFFF, 3'd4, 1'b1, 16'h0001, 1'b0});
        vecs.push_back('{24, 2'b10, 16'h8000, 16'hFFFF, 3'd5, 1'b1, 16'h8000, 1'b0});
        vecs.push_back('{25, 2'b11, 16'h8000, 16'hFFFF, 3'd6, 1'b1, 16'h0000, 1'b0});
        vecs.push_back('{26, 2'b10, 16'hFFF9, 16'h0000, 3'd7, 1'b1, 16'hFFFF, 1'b1});
        vecs.push_back('{27, 2'b11, 16'hFFF9, 16'h0000, 3'd0, 1'b1, 16'hFFF9, 1'b1});
        vecs.push_back('{28, 2'b01, 16'hFFFF, 16'hFFFF, 3'd1, 1'b0, 16'hFFFE, 1'b0});
`endif

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset_busy", -1, bus.Busy, 0);
        check("reset_regwrite", -1, bus.RegWrite, 0);
        check("reset_writereg", -1, bus.WriteReg, 0);
        check("reset_writedata", -1, bus.WriteData, 0);
        check("reset_dbz", -1, bus.DivByZero, 0);
        reset_n = 1'b1;

        foreach (vecs[i]) run_and_check(vecs[i]);

        // Handshake: Start held high with junk operands during RUN; second
        // request (set up in the IDLE cycle) must be accepted at E18.
        begin
            vec_t v0;
            int   rw_cnt;
            int   rw1;
            int   rw2;
            logic [15:0] d1, d2;
            logic [2:0]  r1, r2;
            logic        busy17, busy18;
            v0 = '{30, 2'b00, 16'h0123, 16'h0456, 3'd5, 1'b0, 16'hEDC2, 1'b0};
            rw_cnt = 0; rw1 = -1; rw2 = -1; d1 = '0; d2 = '0; r1 = '0; r2 = '0;
            busy17 = 1'bx; busy18 = 1'bx;
            @(negedge clock);
            drive(1'b1, v0.op, v0.a, v0.b, v0.dest, 1'b0);
            @(posedge clock);
            #1;
            for (int c = 0; c < 45; c++) begin
                if (c == 17) busy17 = bus.Busy;
                if (c == 18) busy18 = bus.Busy;
                if (bus.RegWrite) begin
                    rw_cnt++;
                    if (rw_cnt == 1) begin rw1 = c; d1 = bus.WriteData; r1 = bus.WriteReg; end
                    if (rw_cnt == 2) begin rw2 = c; d2 = bus.WriteData; r2 = bus.WriteReg; end
                end
                if (c < 17) drive(1'b1, 2'(c), 16'(c * 16'h1111), 16'(c + 3), 3'(c), 1'b0);
                else if (c == 17) drive(1'b1, 2'b01, 16'hFFFF, 16'hFFFF, 3'd2, 1'b0);
                else drive(1'b0, 2'b00, 16'h0000, 16'h0000, 3'd0, 1'b0);
                @(posedge clock);
                #1;
            end
            check("hs_first_rw", 30, rw1, 16);
            check("hs_first_data", 30, d1, 16'hEDC2);
            check("hs_first_reg", 30, r1, 3'd5);
            check("hs_idle_gap", 30, busy17, 1'b0);
            check("hs_reaccept", 30, busy18, 1'b1);
            check("hs_second_rw", 30, rw2, 34);
            check("hs_second_data", 30, d2, 16'hFFFE);
            check("hs_second_reg", 30, r2, 3'd2);
            check("hs_pulse_count", 30, rw_cnt, 2);
        end

        // Reset asserted for one edge at E8 of a MUL.
        begin
            vec_t v1;
            int   stray_rw;
            int   stray_busy;
            v1 = '{31, 2'b00, 16'h0123, 16'h0456, 3'd6, 1'b0, 16'hEDC2, 1'b0};
            stray_rw = 0;
            stray_busy = 0;
            issue(v1);
            repeat (7) begin
                @(posedge clock);
                #1;
            end
            reset_n = 1'b0;
            @(posedge clock);
            #1;
            reset_n = 1'b1;
            check("rst_mid_busy", 31, bus.Busy, 0);
            check("rst_mid_regwrite", 31, bus.RegWrite, 0);
            check("rst_mid_writereg", 31, bus.WriteReg, 0);
            check("rst_mid_writedata", 31, bus.WriteData, 0);
            check("rst_mid_dbz", 31, bus.DivByZero, 0);
            for (int c = 0; c < 30; c++) begin
                if (bus.RegWrite) stray_rw++;
                if (bus.Busy) stray_busy++;
                @(posedge clock);
                #1;
            end
            check("rst_mid_no_regwrite", 31, stray_rw, 0);
            check("rst_mid_no_busy", 31, stray_busy, 0);
            run_and_check('{32, 2'b10, 16'd1000, 16'd7, 3'd3, 1'b0, 16'h008E, 1'b0});
        end

        // Start and reset at the same edge: reset wins.
        begin
            int busy_seen;
            busy_seen = 0;
            @(negedge clock);
            reset_n = 1'b0;
            drive(1'b1, 2'b00, 16'h0003, 16'h0005, 3'd4, 1'b0);
            @(posedge clock);
            #1;
            reset_n = 1'b1;
            drive(1'b0, 2'b00, 16'h0000, 16'h0000, 3'd0, 1'b0);
            for (int c = 0; c < 20; c++) begin
                if (bus.Busy || bus.RegWrite) busy_seen++;
                @(posedge clock);
                #1;
            end
            check("rst_start_ignored", 33, busy_seen, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide execute unit; sits directly downstream of the 8x16 register file.
- Takes two operands read from the register file and computes one bit per cycle.
- Presents the result on a write-back port (RegWrite/WriteReg/WriteData) that drives the register file write port directly.
- Start/Busy handshake toward the control unit, which stalls issue while Busy=1.

Parameters:
- WIDTH, 16, operand/result width; latency scales with it.
- REG_ADDR_W, 3, destination register address width (8 registers).

Ports:
- clock  in  1  single system clock; all state updates on posedge.
- reset_n  in  1  synchronous active-low reset.
- Start  in  1  request; sampled only in IDLE.
- Op  in  2  00 MUL low half, 01 MUL high half, 10 DIV quotient, 11 REM remainder.
- OperandA  in  WIDTH  multiplicand / dividend (Data1 from register file).
- OperandB  in  WIDTH  multiplier / divisor (Data2 from register file).
- DestReg  in  REG_ADDR_W  destination register for the result.
- Busy  out  1  high from acceptance until the write-back cycle inclusive.
- RegWrite  out  1  one-cycle write-enable pulse to the register file.
- WriteReg  out  REG_ADDR_W  destination address; valid when RegWrite=1.
- WriteData  out  WIDTH  result; valid when RegWrite=1.
- DivByZero  out  1  high together with RegWrite when Op is DIV/REM and the divisor is 0.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-low on `reset_n`.
- Reset values: state IDLE; Busy=0, RegWrite=0, WriteReg=0, WriteData=0, DivByZero=0; internal counter and working registers cleared.
- States:
  - IDLE: Busy=0. Start=1 at edge E0 captures Op, OperandA, OperandB and DestReg, then goes to RUN with count=0.
  - RUN: Busy=1. One iteration per edge at E1..EWIDTH; after the WIDTH-th iteration, go to DONE.
  - DONE: Busy=1, RegWrite=1 for exactly one cycle with WriteReg, WriteData and DivByZero valid. Next edge goes to IDLE with RegWrite=0.
- Latency: RegWrite is high in the cycle following edge EWIDTH (16 clock edges after acceptance at the default width). Fixed for every Op, including divide-by-zero.
- Throughput: Start is ignored whenever state is not IDLE. Earliest next acceptance is edge EWIDTH+2.
- Operand capture: inputs are sampled only at acceptance. Later changes to Op, Operands or DestReg have no effect on the operation in flight.
- Multiply (shift-add):
  - 2*WIDTH-bit unsigned product.
  - Op=00 returns product[WIDTH-1:0]; Op=01 returns product[2*WIDTH-1:WIDTH].
- Divide (restoring):
  - Unsigned quotient/remainder; Op=10 returns quotient, Op=11 returns remainder.
- Divide by zero: quotient = all ones (0xFFFF); remainder = dividend; DivByZero=1 in the DONE cycle, 0 otherwise.
- Outputs outside DONE: WriteData and WriteReg hold their last values; RegWrite=0 and DivByZero=0.
- Reset mid-operation: reset_n=0 at any edge forces IDLE with reset values. The in-flight operation is discarded and no RegWrite is issued.
- Start and reset_n=0 at the same edge: reset wins and Start is not accepted.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- When defined, the unit gains input port Signed (1 bit), captured at acceptance.
  - Signed=1: operands are two's complement. The iteration runs on magnitudes and the sign is fixed in DONE with no extra latency.
  - Product sign = XOR of operand signs; quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x8000 / 0xFFFF gives quotient 0x8000, remainder 0x0000, DivByZero=0.
  - Signed divide by zero: quotient 0xFFFF, remainder = dividend.
- When not defined: no Signed port; all operations are unsigned.

Test Plan:
- MUL: A=0x0123, B=0x0456, Op=00 then Op=01 -> WriteData 0xEDC2, then 0x0004; RegWrite a single pulse 16 cycles after each acceptance; WriteReg=DestReg.
- DIV/REM: A=1000, B=7, Op=10 then Op=11 -> 0x008E, then 0x0006; DivByZero=0.
- Divide by zero: A=0x1234, B=0, Op=10 then Op=11 -> 0xFFFF with DivByZero=1, then 0x1234 with DivByZero=1.
- Handshake: Start held high and operands changed throughout RUN -> only the first request is executed with its original operands; the next acceptance occurs at EWIDTH+2; Busy is high for exactly WIDTH+1 cycles per operation.
- Reset mid-op: reset_n=0 for one edge at E8 of a MUL -> Busy=0 and all outputs at reset values next cycle; no RegWrite ever issued; a new Start afterwards completes normally.
- MULDIV_SIGNED_EN: Signed=1, -7 / 2 -> quotient 0xFFFD, remainder 0xFFFF. 0xFFFF*0xFFFF Op=01 -> 0x0000 signed; 0xFFFE with Signed=0.
